debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Multi-channel, parametrised debouncer for push-buttons and switches. It feeds the RPN calculator's key-decode and operator logic.
- Each channel has its own N-stage synchroniser, a stability counter, a registered clean level, and one-cycle rise and fall strobes.
- It replaces the single-channel debouncer and the separate falling-edge detector with one instance covering all keys.

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- COUNT_MAX, 1_500_000: clock cycles the synchronised input must differ from out before out updates. 30 ms at 50 MHz. Must be ≥1.
- SYNC_STAGES, 2: synchroniser flop depth (≥2).
- RESET_VAL, 0: level loaded into out and all sync flops on reset. Applies to all channels.
- Derived localparam CNT_W = $clog2(COUNT_MAX+1): per-channel counter width. It is not overridable.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in  in  CHANNELS  raw asynchronous button or switch levels.
- out  out  CHANNELS  debounced, registered levels.
- rise  out  CHANNELS  one-cycle pulse when out[i] goes 0→1.
- fall  out  CHANNELS  one-cycle pulse when out[i] goes 1→0.
- busy  out  CHANNELS  high while counter[i] ≠ 0, i.e. a candidate change is being qualified.

Behaviour:
- Reset (async, immediate):
  - All sync flops = RESET_VAL; out = RESET_VAL.
  - counters = 0; rise = fall = busy = 0.
  - No strobe is generated on reset release.
- Channels are fully independent; no shared state.
- Synchroniser: s[i] is the output of the SYNC_STAGES-deep flop chain on in[i]. A change on in[i] ahead of edge 1 appears on s[i] after edge SYNC_STAGES.
- Per-channel counter, evaluated every rising edge:
  - s[i] == out[i]: counter ← 0.
  - s[i] ≠ out[i] and counter < COUNT_MAX−1: counter ← counter+1.
  - s[i] ≠ out[i] and counter == COUNT_MAX−1: out[i] ← s[i]; counter ← 0.
- Strobes:
  - rise[i] ← (out[i] being updated 0→1); fall[i] ← (out[i] being updated 1→0).
  - Both are registered on the same edge as the out update, so a strobe is high for exactly the first cycle of the new level.
  - rise and fall are never both high on one channel.
- Latency: out[i] changes on rising edge SYNC_STAGES+COUNT_MAX after the edge where in[i] was first sampled at its new level.
  - This holds only if s[i] stays at that level for COUNT_MAX consecutive edges.
  - With COUNT_MAX=1, out follows s with one extra cycle.
- Glitch rejection:
  - Any return of s[i] to out[i] before the qualifying edge clears the counter. No out change, no strobe.
  - A pulse lasting exactly COUNT_MAX cycles of s passes. COUNT_MAX−1 cycles is rejected.
- Bounce: qualification restarts from zero at every s[i] transition. Timing is measured from the last transition.
- Counter never exceeds COUNT_MAX−1; no wrap-around is possible.
- Reset mid-qualification: the counter is discarded and out returns to RESET_VAL. After release, a still-differing input requires a full COUNT_MAX qualification.
- busy[i] is combinational from counter[i] ≠ 0 and is glitch-free because it is a register compare.
- No combinational path from in to any output.

Test Plan (CHANNELS=4, COUNT_MAX=4, SYNC_STAGES=2, RESET_VAL=0, edges counted from first sample of new input level):
- Reset with in=4'b0000, then release → out=0000, rise=fall=busy=0000 for 20 cycles.
- in[0] 0→1 and held:
  - busy[0] is high after edges 3–5.
  - out[0]=1 after edge 6; rise[0]=1 for that single cycle only.
  - out[3:1] and all other strobes stay 0.
- in[1] high for 3 cycles, then low:
  - busy[1] pulses; out[1] stays 0 throughout; rise[1]/fall[1] never assert.
  - The same stimulus held for 4 cycles → out[1]=1, then returns to 0 six edges after the fall, with one rise and one fall strobe.
- in[2] bounce pattern 1,0,1,0,1 then held high → out[2]=1 exactly 6 edges after the final 0→1, with a single rise[2] strobe.
- With out[3]=1 (pre-qualified), drive in[2] 0→1 and in[3] 1→0 on the same cycle → rise[2] and fall[3] assert in the same cycle; out=4'b0100.
- Assert reset asynchronously while counter[0]=2 (in[0] held high):
  - out, busy, and strobes clear before the next edge.
  - After release, out[0]=1 only after the full 6-edge qualification, with exactly one rise[0].

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel debouncer for push-buttons and switches.
// Each channel synchronises its raw input, requires the synchronised level to
// differ from the clean output for COUNT_MAX consecutive edges, then updates
// the clean output and emits a one-cycle rise or fall strobe.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   in     - raw asynchronous levels, one bit per channel
//   out    - debounced, registered levels
//   rise   - one-cycle pulse on the first cycle of out[i] == 1 after a 0
//   fall   - one-cycle pulse on the first cycle of out[i] == 0 after a 1
//   busy   - high while the channel is qualifying a candidate change
module debounce_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned COUNT_MAX   = 1_500_000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    localparam int unsigned CNT_W = $clog2(COUNT_MAX + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [CHANNELS-1:0] RST_LVL  = {CHANNELS{RESET_VAL}};

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  s;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_d;
    logic [CHANNELS-1:0]                  out_d;
    logic [CHANNELS-1:0]                  rise_d;
    logic [CHANNELS-1:0]                  fall_d;

    // Synchroniser chain: stage 0 samples the raw input, last stage is s.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_LVL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Qualification: any agreement between s and out restarts the count;
    // the edge that would take the count to COUNT_MAX commits the new level.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (s[i] == out[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]  = '0;
                out_d[i]  = s[i];
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter, clean level and strobes share one register stage so a strobe
    // coincides with the first cycle of the new level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            out   <= RST_LVL;
            rise  <= '0;
            fall  <= '0;
        end else begin
            cnt_q <= cnt_d;
            out   <= out_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

    // Busy is a decode of the counter register only.
    always_comb begin
        busy = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank with CHANNELS=4, COUNT_MAX=4, SYNC_STAGES=2.
module tb_debounce_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] in_v  = 4'b0000;
    logic [3:0] out_v;
    logic [3:0] rise_v;
    logic [3:0] fall_v;
    logic [3:0] busy_v;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] b;
    } exp_t;

    typedef struct {
        logic [3:0] i;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    debounce_bank #(
        .CHANNELS   (4),
        .COUNT_MAX  (4),
        .SYNC_STAGES(2),
        .RESET_VAL  (1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in   (in_v),
        .out  (out_v),
        .rise (rise_v),
        .fall (fall_v),
        .busy (busy_v)
    );

    task automatic chk(input string name, input int idx, input string fld,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] %s: got %b expected %b", name, idx, fld, act, exp);
        end
    endtask

    task automatic check_now(input string name, input int idx, input exp_t e);
        chk(name, idx, "out",  out_v,  e.o);
        chk(name, idx, "rise", rise_v, e.r);
        chk(name, idx, "fall", fall_v, e.f);
        chk(name, idx, "busy", busy_v, e.b);
    endtask

    task automatic add(input logic [3:0] i, input logic [3:0] o, input logic [3:0] r,
                       input logic [3:0] f, input logic [3:0] b);
        vec_t v;
        v.i   = i;
        v.e.o = o;
        v.e.r = r;
        v.e.f = f;
        v.e.b = b;
        tbl.push_back(v);
    endtask

    // Drive each vector before an edge, pop its expectation after the edge.
    task automatic run_tbl(input string name);
        exp_t e;
        for (int k = 0; k < tbl.size(); k++) begin
            in_v = tbl[k].i;
            sb_q.push_back(tbl[k].e);
            @(posedge clock);
            #1;
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL %s[%0d] scoreboard: got empty queue expected entry", name, k + 1);
            end else begin
                e = sb_q.pop_front();
                check_now(name, k + 1, e);
            end
        end
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t z;
        z = '0;

        // Reset applied, then released; quiet for 20 cycles.
        reset = 1'b1;
        #2;
        check_now("reset_async", 0, z);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("idle");

        // Channel 0 rises and is held.
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("ch0_rise");

        // Channel 1 high for 3 cycles: rejected.
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("ch1_glitch3");

        // Channel 1 high for 4 cycles: passes, then falls six edges later.
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0011, 4'b0010, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("ch1_pulse4");

        // Channel 2 bounces 1,0,1,0,1 then holds high.
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0101, 4'b0101, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("ch2_bounce");

        // Move to out=1000 with three channels changing at once.
        add(4'b1000, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1000, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1000, 4'b0101, 4'b0000, 4'b0000, 4'b1101);
        add(4'b1000, 4'b0101, 4'b0000, 4'b0000, 4'b1101);
        add(4'b1000, 4'b0101, 4'b0000, 4'b0000, 4'b1101);
        add(4'b1000, 4'b1000, 4'b1000, 4'b0101, 4'b0000);
        add(4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("setup_ch3");

        // Channel 2 rises while channel 3 falls on the same cycle.
        add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b1100);
        add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b1100);
        add(4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b1100);
        add(4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0000);
        add(4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("simul_rf");

        // Reset while channel 0 is two counts into qualification.
        add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0001);
        run_tbl("pre_reset");
        reset = 1'b1;
        #2;
        check_now("mid_reset", 0, z);
        @(posedge clock);
        #1;
        check_now("reset_held", 0, z);
        reset = 1'b0;

        // Full requalification after release.
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
        add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
        add(4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        run_tbl("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
